// File: rtl/fp32_pkg.sv
// Shared types, constants and helpers for the binary32 round/pack back-end.
package fp32_pkg;

   // Bit positions inside the one-hot rounding-mode input
   localparam int RM_RNE = 0;
   localparam int RM_RNA = 1;
   localparam int RM_RTP = 2;
   localparam int RM_RTN = 3;
   localparam int RM_RTZ = 4;

   // Encodings of the special results (magnitudes exclude the sign bit)
   localparam logic [31:0] QNAN = 32'h7fc00000;
   localparam logic [30:0] INF  = 31'h7f800000;
   localparam logic [30:0] MAXF = 31'h7f7fffff;

   // Resolved rounding mode carried with each beat
   typedef enum logic [2:0] {
      RND_RNE = 3'd0,
      RND_RNA = 3'd1,
      RND_RTP = 3'd2,
      RND_RTN = 3'd3,
      RND_RTZ = 3'd4
   } rnd_e;

   // Result class after applying the special-case priority
   typedef enum logic [2:0] {
      CLS_FIN     = 3'd0,
      CLS_QNAN    = 3'd1,
      CLS_INVALID = 3'd2,
      CLS_DZ      = 3'd3,
      CLS_INF     = 3'd4,
      CLS_ZERO    = 3'd5
   } cls_e;

   // Stage-1 register bundle: denormalised operand ready for rounding
   typedef struct packed {
      logic        sign;
      logic [7:0]  e;
      logic [26:0] sig;
      logic        sticky;
      cls_e        cls;
      rnd_e        rnd;
      logic        ovf;
   } s1_t;

   // Lowest set bit of rm wins; an empty mask falls back to truncation.
   function automatic rnd_e decode_rm(input logic [4:0] rm);
      rnd_e r;
      if (rm[RM_RNE]) begin
         r = RND_RNE;
      end else if (rm[RM_RNA]) begin
         r = RND_RNA;
      end else if (rm[RM_RTP]) begin
         r = RND_RTP;
      end else if (rm[RM_RTN]) begin
         r = RND_RTN;
      end else begin
         r = RND_RTZ;
      end
      return r;
   endfunction

   // Round-up decision from lsb, guard and the merged round/sticky bit.
   function automatic logic round_inc(input rnd_e rnd, input logic sign,
                                      input logic lsb, input logic g, input logic r);
      logic inc;
      case (rnd)
         RND_RNE: inc = g & (r | lsb);
         RND_RNA: inc = g;
         RND_RTP: inc = ~sign & (g | r);
         RND_RTN: inc = sign & (g | r);
         RND_RTZ: inc = 1'b0;
         default: inc = 1'b0;
      endcase
      return inc;
   endfunction

   // Overflowed magnitude: infinity when rounding away from zero, else max finite.
   function automatic logic [30:0] ovf_mag(input rnd_e rnd, input logic sign);
      logic [30:0] m;
      case (rnd)
         RND_RNE: m = INF;
         RND_RNA: m = INF;
         RND_RTZ: m = MAXF;
         RND_RTP: m = sign ? MAXF : INF;
         RND_RTN: m = sign ? INF : MAXF;
         default: m = INF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fp32_denorm_shift.sv
// Saturating right shift of the significand; every bit pushed off the
// bottom is folded into a sticky bit.
module fp32_denorm_shift
   import fp32_pkg::*;
(
   input  logic [26:0] sig,
   input  logic [4:0]  amt,
   output logic [26:0] sig_out,
   output logic        sticky_out
);

   logic [54:0] wide_s;

   // Shift into a zero-padded window so the lost bits land in the low half
   always_comb begin
      wide_s     = {sig, 28'd0} >> amt;
      sig_out    = wide_s[54:28];
      sticky_out = |wide_s[27:0];
   end

endmodule

// File: rtl/fp32_round_pack.sv
// Two-stage binary32 back-end: stage 1 classifies and denormalises,
// stage 2 rounds, detects overflow/underflow and packs the word.
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [26:0] in_sig,
   input  logic        in_sticky,
   input  logic        in_zero,
   input  logic        in_inf,
   input  logic        in_nan,
   input  logic        in_nv,
   input  logic        in_dz,
   input  logic [4:0]  rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] o,
   output logic        NV,
   output logic        DZ,
   output logic        OF,
   output logic        UF,
   output logic        NX
);

   logic        s1_valid_r;
   logic        s2_valid_r;
   logic        s1_load_s;
   logic        s2_load_s;
   s1_t         s1_r;
   s1_t         s1_next_s;

   logic        subn_s;
   logic [10:0] sh_full_s;
   logic [4:0]  sh_amt_s;
   logic [26:0] sh_sig_s;
   logic        sh_sticky_s;
   cls_e        cls_s;

   logic        lsb_s;
   logic        g_s;
   logic        r_s;
   logic        inc_s;
   logic        nx_s;
   logic        of_s;
   logic [31:0] mag_s;
   logic [31:0] res_o_s;
   logic        res_nv_s;
   logic        res_dz_s;
   logic        res_of_s;
   logic        res_uf_s;
   logic        res_nx_s;

   logic [31:0] o_r;
   logic        nv_r;
   logic        dz_r;
   logic        of_r;
   logic        uf_r;
   logic        nx_r;

   // The integer bit is implied by the exponent field once denormalised
   logic        int_bit_unused;
   assign int_bit_unused = s1_r.sig[26];

   // Pipeline advance: a stage loads when empty or when its successor drains it
   always_comb begin
      s2_load_s = !s2_valid_r || out_ready;
      s1_load_s = !s1_valid_r || s2_load_s;
   end

   assign in_ready = s1_load_s;

   // Right-shift amount for results below the normal range, capped at 28
   always_comb begin
      subn_s    = ($signed(in_exp) < 10'sd1);
      sh_full_s = 11'd1 - {in_exp[9], in_exp};
      if (!subn_s) begin
         sh_amt_s = 5'd0;
      end else if (sh_full_s > 11'd28) begin
         sh_amt_s = 5'd28;
      end else begin
         sh_amt_s = sh_full_s[4:0];
      end
   end

   fp32_denorm_shift u_denorm (
      .sig        (in_sig),
      .amt        (sh_amt_s),
      .sig_out    (sh_sig_s),
      .sticky_out (sh_sticky_s)
   );

   // Classify the beat and assemble the stage-1 bundle
   always_comb begin
      if (in_nv || in_nan) begin
         if (in_nv) begin
            cls_s = CLS_INVALID;
         end else begin
            cls_s = CLS_QNAN;
         end
      end else if (in_dz) begin
         cls_s = CLS_DZ;
      end else if (in_inf) begin
         cls_s = CLS_INF;
      end else if (in_zero || (in_sig == 27'd0)) begin
         cls_s = CLS_ZERO;
      end else begin
         cls_s = CLS_FIN;
      end
      s1_next_s.sign   = in_sign;
      s1_next_s.e      = subn_s ? 8'd0 : in_exp[7:0];
      s1_next_s.sig    = sh_sig_s;
      s1_next_s.sticky = in_sticky || sh_sticky_s;
      s1_next_s.cls    = cls_s;
      s1_next_s.rnd    = decode_rm(rm);
      s1_next_s.ovf    = ($signed(in_exp) >= 10'sd255);
   end

   // Stage-1 register: captures an accepted beat together with its rounding mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_r       <= '0;
      end else if (s1_load_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_r <= s1_next_s;
         end
      end
   end

   // Round, detect overflow/underflow and select the packed result
   always_comb begin
      lsb_s = s1_r.sig[3];
      g_s   = s1_r.sig[2];
      r_s   = (s1_r.sig[1:0] != 2'b00) || s1_r.sticky;
      inc_s = round_inc(s1_r.rnd, s1_r.sign, lsb_s, g_s, r_s);
      nx_s  = g_s || r_s;
      // Carry out of the fraction walks into the exponent field on its own
      mag_s = {1'b0, s1_r.e, s1_r.sig[25:3]} + {31'd0, inc_s};
      of_s  = s1_r.ovf || (mag_s >= {1'b0, INF});

      res_o_s  = 32'd0;
      res_nv_s = 1'b0;
      res_dz_s = 1'b0;
      res_of_s = 1'b0;
      res_uf_s = 1'b0;
      res_nx_s = 1'b0;
      case (s1_r.cls)
         CLS_QNAN: begin
            res_o_s = QNAN;
         end
         CLS_INVALID: begin
            res_o_s  = QNAN;
            res_nv_s = 1'b1;
         end
         CLS_DZ: begin
            res_o_s  = {s1_r.sign, INF};
            res_dz_s = 1'b1;
         end
         CLS_INF: begin
            res_o_s = {s1_r.sign, INF};
         end
         CLS_ZERO: begin
            res_o_s = {s1_r.sign, 31'd0};
         end
         CLS_FIN: begin
            if (of_s) begin
               res_o_s  = {s1_r.sign, ovf_mag(s1_r.rnd, s1_r.sign)};
               res_of_s = 1'b1;
               res_nx_s = 1'b1;
            end else begin
               res_o_s  = {s1_r.sign, mag_s[30:0]};
               res_nx_s = nx_s;
               // Tininess is judged on the rounded exponent field
               res_uf_s = (mag_s[30:23] == 8'd0) && nx_s;
            end
         end
         default: begin
            res_o_s = QNAN;
         end
      endcase
   end

   // Stage-2 register: output word and flags, frozen while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         o_r        <= 32'd0;
         nv_r       <= 1'b0;
         dz_r       <= 1'b0;
         of_r       <= 1'b0;
         uf_r       <= 1'b0;
         nx_r       <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            o_r  <= res_o_s;
            nv_r <= res_nv_s;
            dz_r <= res_dz_s;
            of_r <= res_of_s;
            uf_r <= res_uf_s;
            nx_r <= res_nx_s;
         end
      end
   end

   assign out_valid = s2_valid_r;
   assign o         = o_r;
   assign NV        = nv_r;
   assign DZ        = dz_r;
   assign OF        = of_r;
   assign UF        = uf_r;
   assign NX        = nx_r;

endmodule

// File: tb/tb_fp32_round_pack.sv
// Directed-vector bench for fp32_round_pack: per-beat latency/value checks,
// a randomly back-pressured stream, a stall sequence and a mid-stall reset.
module tb_fp32_round_pack;

   typedef struct {
      logic        sign;
      logic [9:0]  e;
      logic [26:0] sig;
      logic        sticky;
      logic        zero;
      logic        inf;
      logic        nan;
      logic        nv;
      logic        dz;
      logic [4:0]  rm;
      logic [31:0] exp_o;
      logic [4:0]  exp_fl;
   } vec_t;

   localparam int NUM = 26;

   localparam logic [26:0] ONE  = 27'h4000000;
   localparam logic [26:0] TIE  = 27'h4000004;
   localparam logic [26:0] ALL1 = 27'h7ffffff;
   localparam logic [4:0]  RNE = 5'b00001;
   localparam logic [4:0]  RNA = 5'b00010;
   localparam logic [4:0]  RTP = 5'b00100;
   localparam logic [4:0]  RTN = 5'b01000;
   localparam logic [4:0]  RTZ = 5'b10000;
   // flag order {NV, DZ, OF, UF, NX}
   localparam logic [4:0]  F_NX = 5'b00001;
   localparam logic [4:0]  F_UF = 5'b00010;
   localparam logic [4:0]  F_OF = 5'b00100;
   localparam logic [4:0]  F_DZ = 5'b01000;
   localparam logic [4:0]  F_NV = 5'b10000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [26:0] in_sig;
   logic        in_sticky;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        in_nv;
   logic        in_dz;
   logic [4:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] o;
   logic        NV, DZ, OF, UF, NX;

   vec_t vecs[NUM];
   int   n_checks = 0;
   int   n_pass = 0;
   int   sent;
   int   got;
   logic acc;
   int   bp_idx[4] = '{0, 2, 3, 5};

   fp32_round_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_sig    (in_sig),
      .in_sticky (in_sticky),
      .in_zero   (in_zero),
      .in_inf    (in_inf),
      .in_nan    (in_nan),
      .in_nv     (in_nv),
      .in_dz     (in_dz),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .NV        (NV),
      .DZ        (DZ),
      .OF        (OF),
      .UF        (UF),
      .NX        (NX)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk_fin(input logic sign, input logic [9:0] e, input logic [26:0] sig,
                                   input logic sticky, input logic [4:0] m,
                                   input logic [31:0] xo, input logic [4:0] xf);
      vec_t v;
      v.sign = sign; v.e = e; v.sig = sig; v.sticky = sticky;
      v.zero = 1'b0; v.inf = 1'b0; v.nan = 1'b0; v.nv = 1'b0; v.dz = 1'b0;
      v.rm = m; v.exp_o = xo; v.exp_fl = xf;
      return v;
   endfunction

   function automatic vec_t mk_spc(input logic sign, input logic zero, input logic inf,
                                   input logic nan, input logic nv, input logic dz,
                                   input logic [31:0] xo, input logic [4:0] xf);
      vec_t v;
      v.sign = sign; v.e = 10'd127; v.sig = ONE; v.sticky = 1'b0;
      v.zero = zero; v.inf = inf; v.nan = nan; v.nv = nv; v.dz = dz;
      v.rm = RNE; v.exp_o = xo; v.exp_fl = xf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] xp);
      n_checks++;
      if (act !== xp) begin
         $display("FAIL %s: got %h expected %h", name, act, xp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic set_in(input vec_t v);
      in_sign   = v.sign;
      in_exp    = v.e;
      in_sig    = v.sig;
      in_sticky = v.sticky;
      in_zero   = v.zero;
      in_inf    = v.inf;
      in_nan    = v.nan;
      in_nv     = v.nv;
      in_dz     = v.dz;
      rm        = v.rm;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk_fin(1'b0, 10'd127, ONE,  1'b0, RNE, 32'h3f800000, 5'b00000);
      vecs[1]  = mk_fin(1'b0, 10'd127, TIE,  1'b0, RNE, 32'h3f800000, F_NX);
      vecs[2]  = mk_fin(1'b0, 10'd127, TIE,  1'b0, RNA, 32'h3f800001, F_NX);
      vecs[3]  = mk_fin(1'b1, 10'd127, TIE,  1'b0, RTN, 32'hbf800001, F_NX);
      vecs[4]  = mk_fin(1'b0, 10'd255, ONE,  1'b0, RNE, 32'h7f800000, F_OF | F_NX);
      vecs[5]  = mk_fin(1'b0, 10'd255, ONE,  1'b0, RTZ, 32'h7f7fffff, F_OF | F_NX);
      vecs[6]  = mk_fin(1'b1, 10'd255, ONE,  1'b0, RTN, 32'hff800000, F_OF | F_NX);
      vecs[7]  = mk_fin(1'b1, 10'd255, ONE,  1'b0, RTP, 32'hff7fffff, F_OF | F_NX);
      vecs[8]  = mk_fin(1'b0, 10'h3ea, ONE,  1'b0, RNE, 32'h00000001, 5'b00000);
      vecs[9]  = mk_fin(1'b0, 10'h3e9, ONE,  1'b0, RNE, 32'h00000000, F_UF | F_NX);
      vecs[10] = mk_fin(1'b0, 10'h3e9, ONE,  1'b0, RTP, 32'h00000001, F_UF | F_NX);
      vecs[11] = mk_spc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7fc00000, 5'b00000);
      vecs[12] = mk_spc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7fc00000, F_NV);
      vecs[13] = mk_spc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hff800000, F_DZ);
      vecs[14] = mk_fin(1'b0, 10'd127, ALL1, 1'b0, RNE, 32'h40000000, F_NX);
      vecs[15] = mk_fin(1'b0, 10'd0,   ALL1, 1'b0, RNE, 32'h00800000, F_NX);
      vecs[16] = mk_fin(1'b0, 10'd254, ALL1, 1'b0, RNE, 32'h7f800000, F_OF | F_NX);
      vecs[17] = mk_fin(1'b0, 10'd127, TIE,  1'b0, 5'b00000, 32'h3f800000, F_NX);
      vecs[18] = mk_fin(1'b1, 10'd127, TIE,  1'b0, 5'b00110, 32'hbf800001, F_NX);
      vecs[19] = mk_fin(1'b0, 10'd127, ONE,  1'b1, RTP, 32'h3f800001, F_NX);
      vecs[20] = mk_spc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'b00000);
      vecs[21] = mk_spc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7fc00000, 5'b00000);
      vecs[22] = mk_spc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7f800000, F_DZ);
      vecs[23] = mk_fin(1'b0, 10'd100, 27'd0, 1'b0, RNE, 32'h00000000, 5'b00000);
      vecs[24] = mk_spc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hff800000, 5'b00000);
      vecs[25] = mk_fin(1'b0, 10'h2d4, ONE,  1'b0, RTP, 32'h00000001, F_UF | F_NX);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_in(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset o", o, 32'd0);
      check("reset flags", {27'd0, NV, DZ, OF, UF, NX}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);

      // One beat at a time: exact 2-cycle latency and result per vector
      for (int i = 0; i < NUM; i++) begin
         set_in(vecs[i]);
         in_valid = 1'b1;
         #1;
         check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check($sformatf("v%0d lat1 out_valid", i), {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("v%0d lat2 out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("v%0d o", i), o, vecs[i].exp_o);
         check($sformatf("v%0d flags", i), {27'd0, NV, DZ, OF, UF, NX}, {27'd0, vecs[i].exp_fl});
      end
      @(posedge clk);
      #1;

      // Back-to-back stream under random backpressure
      sent = 0;
      got  = 0;
      for (int c = 0; c < 600 && got < NUM; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (sent < NUM) begin
            set_in(vecs[sent]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            check($sformatf("stream o #%0d", got), o, vecs[got].exp_o);
            check($sformatf("stream flags #%0d", got), {27'd0, NV, DZ, OF, UF, NX},
                  {27'd0, vecs[got].exp_fl});
            got++;
         end
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      in_valid = 1'b0;
      check("stream count", got, NUM);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Stall: out_ready low for 5 cycles while offering 4 beats
      out_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 5; c++) begin
         if (sent < 4) begin
            set_in(vecs[bp_idx[sent]]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      check("bp accepted", sent, 2);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp o held", o, vecs[bp_idx[0]].exp_o);
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (sent < 4) begin
            set_in(vecs[bp_idx[sent]]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid) begin
            check($sformatf("bp order #%0d", got), o, vecs[bp_idx[got]].exp_o);
            got++;
         end
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      in_valid = 1'b0;
      check("bp got all", got, 4);
      @(posedge clk);
      #1;
      check("bp no duplicate", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a stall discards everything in flight
      out_ready = 1'b0;
      set_in(vecs[2]);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("rst pre out_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async out_valid", {31'd0, out_valid}, 32'd0);
      check("rst async o", o, 32'd0);
      check("rst async flags", {27'd0, NV, DZ, OF, UF, NX}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst drained %0d", c), {31'd0, out_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
